ray_march_step: RTL and testbench

RAY_MARCH_STEP -- requirements
Module: ray_march_step

---
 rtl/fixedpoint_pkg.sv | 51 +++++
 rtl/march_pix_fifo.sv | 74 +++++++
 rtl/ray_march_step.sv | 192 +++++++++++++++++++
 tb/tb_ray_march_step.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixedpoint_pkg.sv
// Fixed-point number format, march message layout and pixel result record
// shared by the ray marching step and its pixel result FIFO.
package fixedpoint;
    localparam int WIDTH  = 32;
    localparam int FRAC   = 16;
    localparam int ADDR_W = 16;
    localparam int ITER_W = 8;

    typedef logic signed [WIDTH-1:0] number;

    localparam number ONE     = 32'sh0001_0000;
    localparam number NUM_MAX = 32'sh7fff_ffff;

    typedef struct packed {
        logic [ADDR_W-1:0] mem_addr;
        logic [ITER_W-1:0] march_iter;
        logic [ITER_W-1:0] mb_iter;
        number             pos_x;
        number             pos_y;
        number             pos_z;
        number             rayd_x;
        number             rayd_y;
        number             rayd_z;
        number             x_iter;
        number             y_iter;
        number             z_iter;
        number             r;
        number             dr;
        number             march_depth;
        number             logdist;
        number             epsilon;
    } message;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic [ITER_W-1:0] steps;
        number             depth;
    } pix_entry;

    // Signed fixed-point multiply: full product, rescale, truncate to number width.
    function automatic number fp_mul(input number a, input number b);
        logic signed [2*WIDTH-1:0] a_ext;
        logic signed [2*WIDTH-1:0] b_ext;
        logic signed [2*WIDTH-1:0] prod;
        a_ext = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext = {{WIDTH{b[WIDTH-1]}}, b};
        prod  = a_ext * b_ext;
        return number'(prod >>> FRAC);
    endfunction
endpackage

// File: rtl/march_pix_fifo.sv
// Pixel result FIFO with valid/ready pop and a sticky overflow flag.
// FIFO_DEPTH must be a power of two, at least 2; head reads as zero when empty.
module march_pix_fifo
    import fixedpoint::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_en,
    input  pix_entry wr_data,
    input  logic     rd_ready,
    output logic     rd_valid,
    output pix_entry rd_data,
    output logic     overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    pix_entry           mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               empty_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;

    // A write into a full FIFO only lands if the head leaves in the same cycle.
    always_comb begin
        empty_s = (count_r == {CNT_W{1'b0}});
        full_s  = (count_r == CNT_W'(FIFO_DEPTH));
        pop_s   = !empty_s && rd_ready;
        push_s  = wr_en && (!full_s || pop_s);
        drop_s  = wr_en && full_s && !pop_s;
        if (empty_s) begin
            rd_valid = 1'b0;
            rd_data  = '0;
        end else begin
            rd_valid = 1'b1;
            rd_data  = mem_r[rd_ptr_r];
        end
    end

    // Storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ray_march_step.sv
// One sphere-tracing step: three-stage pipeline that either re-injects the ray
// or retires a pixel result. Optional counters under RAY_MARCH_STATS_EN.
module ray_march_step
    import fixedpoint::*;
#(
    parameter int MAX_ITER      = 64,
    parameter int MAX_DEPTH_INT = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  message            data_in,
    output logic              loop_valid,
    output message            loop_out,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_hit,
    output logic [ITER_W-1:0] pix_steps,
    output number             pix_depth,
    input  logic              pix_ready,
    output logic              fifo_overflow
`ifdef RAY_MARCH_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_loops
`endif
);
    localparam number             DEPTH_LIMIT = number'(MAX_DEPTH_INT) <<< FRAC;
    localparam logic [ITER_W-1:0] ITER_LIMIT  = ITER_W'(MAX_ITER);

    number             s1_dist_s;
    logic              s1_hit_s;
    logic              s1_valid_r;
    logic              s1_hit_r;
    number             s1_dist_r;
    message            s1_msg_r;

    logic [WIDTH:0]    depth_sum_s;
    number             s2_depth_s;
    logic              s2_valid_r;
    logic              s2_hit_r;
    number             s2_step_x_r;
    number             s2_step_y_r;
    number             s2_step_z_r;
    number             s2_depth_r;
    message            s2_msg_r;

    logic [ITER_W-1:0] iter_next_s;
    logic              term_s;
    logic              cont_s;
    logic              wr_en_s;
    message            cont_msg_s;
    pix_entry          wr_data_s;
    pix_entry          head_s;

    // S1: negative estimates clamp to zero so the ray never steps backwards.
    always_comb begin
        if (data_in.logdist[WIDTH-1]) begin
            s1_dist_s = '0;
        end else begin
            s1_dist_s = data_in.logdist;
        end
        s1_hit_s = ($signed(s1_dist_s) < $signed(data_in.epsilon));
    end

    // S1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_hit_r   <= 1'b0;
            s1_dist_r  <= '0;
            s1_msg_r   <= '0;
        end else begin
            s1_valid_r <= in_valid;
            s1_hit_r   <= s1_hit_s;
            s1_dist_r  <= s1_dist_s;
            s1_msg_r   <= data_in;
        end
    end

    // S2: dist is never negative, so only positive saturation can occur.
    always_comb begin
        depth_sum_s = {s1_msg_r.march_depth[WIDTH-1], s1_msg_r.march_depth}
                    + {s1_dist_r[WIDTH-1], s1_dist_r};
        if (depth_sum_s[WIDTH:WIDTH-1] == 2'b01) begin
            s2_depth_s = NUM_MAX;
        end else begin
            s2_depth_s = depth_sum_s[WIDTH-1:0];
        end
    end

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            s2_hit_r    <= 1'b0;
            s2_step_x_r <= '0;
            s2_step_y_r <= '0;
            s2_step_z_r <= '0;
            s2_depth_r  <= '0;
            s2_msg_r    <= '0;
        end else begin
            s2_valid_r  <= s1_valid_r;
            s2_hit_r    <= s1_hit_r;
            s2_step_x_r <= fp_mul(s1_msg_r.rayd_x, s1_dist_r);
            s2_step_y_r <= fp_mul(s1_msg_r.rayd_y, s1_dist_r);
            s2_step_z_r <= fp_mul(s1_msg_r.rayd_z, s1_dist_r);
            s2_depth_r  <= s2_depth_s;
            s2_msg_r    <= s1_msg_r;
        end
    end

    // S3: a hit outranks both miss causes; the mandelbulb iterate restarts at the new position.
    always_comb begin
        iter_next_s = s2_msg_r.march_iter + ITER_W'(1);
        term_s      = s2_hit_r
                   || ($signed(s2_depth_r) >= $signed(DEPTH_LIMIT))
                   || (iter_next_s == ITER_LIMIT);
        cont_s      = s2_valid_r && !term_s;
        wr_en_s     = s2_valid_r && term_s;

        cont_msg_s             = s2_msg_r;
        cont_msg_s.pos_x       = s2_msg_r.pos_x + s2_step_x_r;
        cont_msg_s.pos_y       = s2_msg_r.pos_y + s2_step_y_r;
        cont_msg_s.pos_z       = s2_msg_r.pos_z + s2_step_z_r;
        cont_msg_s.x_iter      = s2_msg_r.pos_x + s2_step_x_r;
        cont_msg_s.y_iter      = s2_msg_r.pos_y + s2_step_y_r;
        cont_msg_s.z_iter      = s2_msg_r.pos_z + s2_step_z_r;
        cont_msg_s.march_depth = s2_depth_r;
        cont_msg_s.march_iter  = iter_next_s;
        cont_msg_s.r           = '0;
        cont_msg_s.dr          = ONE;
        cont_msg_s.mb_iter     = '0;

        wr_data_s.addr  = s2_msg_r.mem_addr;
        wr_data_s.hit   = s2_hit_r;
        wr_data_s.steps = iter_next_s;
        wr_data_s.depth = s2_depth_r;
    end

    // S3 register: re-injected ray, zeroed whenever not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_valid <= 1'b0;
            loop_out   <= '0;
        end else begin
            loop_valid <= cont_s;
            loop_out   <= cont_s ? cont_msg_s : '0;
        end
    end

`ifdef RAY_MARCH_STATS_EN
    // Wrapping outcome counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= 32'd0;
            stat_misses <= 32'd0;
            stat_loops  <= 32'd0;
        end else begin
            if (wr_en_s && s2_hit_r) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (wr_en_s && !s2_hit_r) begin
                stat_misses <= stat_misses + 32'd1;
            end
            if (cont_s) begin
                stat_loops <= stat_loops + 32'd1;
            end
        end
    end
`endif

    march_pix_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_s),
        .wr_data  (wr_data_s),
        .rd_ready (pix_ready),
        .rd_valid (pix_valid),
        .rd_data  (head_s),
        .overflow (fifo_overflow)
    );

    assign pix_addr  = head_s.addr;
    assign pix_hit   = head_s.hit;
    assign pix_steps = head_s.steps;
    assign pix_depth = head_s.depth;
endmodule

// File: tb/tb_ray_march_step.sv
// Self-checking bench for ray_march_step: directed cases plus a random stream
// checked every cycle against an arithmetic reference model and a FIFO queue.
module tb_ray_march_step;
    import fixedpoint::*;

    localparam int MAX_ITER      = 64;
    localparam int MAX_DEPTH_INT = 16;
    localparam int FIFO_DEPTH    = 4;

    typedef struct packed {
        logic     valid;
        logic     term;
        logic     hit;
        message   lout;
        pix_entry pe;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    message            data_in;
    logic              loop_valid;
    message            loop_out;
    logic              pix_valid;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_hit;
    logic [ITER_W-1:0] pix_steps;
    number             pix_depth;
    logic              pix_ready;
    logic              fifo_overflow;
`ifdef RAY_MARCH_STATS_EN
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;
    logic [31:0]       stat_loops;
`endif

    int       checks = 0;
    int       errors = 0;
    exp_t     pipe [3];
    pix_entry mq [$];
    bit       m_ovf;
    int       m_hits;
    int       m_misses;
    int       m_loops;

    ray_march_step #(
        .MAX_ITER      (MAX_ITER),
        .MAX_DEPTH_INT (MAX_DEPTH_INT),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .data_in       (data_in),
        .loop_valid    (loop_valid),
        .loop_out      (loop_out),
        .pix_valid     (pix_valid),
        .pix_addr      (pix_addr),
        .pix_hit       (pix_hit),
        .pix_steps     (pix_steps),
        .pix_depth     (pix_depth),
        .pix_ready     (pix_ready),
        .fifo_overflow (fifo_overflow)
`ifdef RAY_MARCH_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses),
        .stat_loops    (stat_loops)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic number scaled(input number r, input longint d);
        longint p;
        p = longint'(r) * d;
        return 32'(p >>> 16);
    endfunction

    // Reference: what one march step should produce for a message, from the rules.
    function automatic exp_t model(input logic v, input message m);
        exp_t   e;
        longint d;
        longint nd;
        longint nit;
        bit     h;
        e = '0;
        if (v) begin
            d   = longint'($signed(m.logdist));
            if (d < 0) d = 0;
            h   = d < longint'($signed(m.epsilon));
            nd  = longint'($signed(m.march_depth)) + d;
            if (nd > 64'sd2147483647) nd = 64'sd2147483647;
            nit = longint'(m.march_iter) + 1;
            e.valid = 1'b1;
            e.hit   = h;
            e.term  = h || (nd >= longint'(MAX_DEPTH_INT) * 65536) || (nit == MAX_ITER);
            if (e.term) begin
                e.pe.addr  = m.mem_addr;
                e.pe.hit   = h;
                e.pe.steps = 8'(nit);
                e.pe.depth = 32'(nd);
            end else begin
                e.lout             = m;
                e.lout.pos_x       = m.pos_x + scaled(m.rayd_x, d);
                e.lout.pos_y       = m.pos_y + scaled(m.rayd_y, d);
                e.lout.pos_z       = m.pos_z + scaled(m.rayd_z, d);
                e.lout.x_iter      = e.lout.pos_x;
                e.lout.y_iter      = e.lout.pos_y;
                e.lout.z_iter      = e.lout.pos_z;
                e.lout.march_depth = 32'(nd);
                e.lout.march_iter  = 8'(nit);
                e.lout.r           = 32'sd0;
                e.lout.dr          = ONE;
                e.lout.mb_iter     = 8'd0;
            end
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        mq.delete();
        m_ovf    = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        m_loops  = 0;
    endtask

    task automatic check_outputs(input exp_t o);
        logic     lv;
        logic     pv;
        message   lo;
        pix_entry hd;
        lv = o.valid && !o.term;
        lo = lv ? o.lout : '0;
        pv = (mq.size() != 0);
        hd = pv ? mq[0] : '0;
        chk("loop_valid", loop_valid, lv);
        chk("loop_out", loop_out, lo);
        chk("pix_valid", pix_valid, pv);
        chk("pix_addr", pix_addr, hd.addr);
        chk("pix_hit", pix_hit, hd.hit);
        chk("pix_steps", pix_steps, hd.steps);
        chk("pix_depth", pix_depth, hd.depth);
        chk("fifo_overflow", fifo_overflow, m_ovf);
`ifdef RAY_MARCH_STATS_EN
        chk("stat_hits", stat_hits, 32'(m_hits));
        chk("stat_misses", stat_misses, 32'(m_misses));
        chk("stat_loops", stat_loops, 32'(m_loops));
`endif
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        exp_t o;
        bit   pop;
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = model(in_valid, data_in);
        o       = pipe[2];
        pop     = (mq.size() > 0) && pix_ready;
        if (o.valid && o.term) begin
            if (mq.size() == FIFO_DEPTH && !pop) m_ovf = 1'b1;
            else mq.push_back(o.pe);
            if (o.hit) m_hits++;
            else m_misses++;
        end else if (o.valid) begin
            m_loops++;
        end
        if (pop) void'(mq.pop_front());
        #1;
        check_outputs(o);
    endtask

    task automatic send(input message m);
        in_valid = 1'b1;
        data_in  = m;
        tick();
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        data_in  = '0;
        rst_n    = 1'b0;
        #1;
        clear_model();
        check_outputs('0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic message base_msg();
        message m;
        m         = '0;
        m.rayd_x  = ONE;
        m.pos_z   = -32'sd131072;
        m.epsilon = 32'sd65;
        return m;
    endfunction

    function automatic message rnd_msg();
        message m;
        m            = '0;
        m.mem_addr   = 16'($urandom);
        m.march_iter = ($urandom_range(0, 7) == 0) ? 8'(MAX_ITER - 1) : 8'($urandom_range(0, MAX_ITER - 2));
        m.mb_iter    = 8'($urandom);
        m.pos_x      = $urandom;
        m.pos_y      = number'(int'($urandom_range(0, 8 * 65536)) - 4 * 65536);
        m.pos_z      = number'(int'($urandom_range(0, 8 * 65536)) - 4 * 65536);
        m.rayd_x     = ($urandom_range(0, 9) == 0) ? number'($urandom) : number'(int'($urandom_range(0, 2 * 65536)) - 65536);
        m.rayd_y     = number'(int'($urandom_range(0, 2 * 65536)) - 65536);
        m.rayd_z     = number'(int'($urandom_range(0, 2 * 65536)) - 65536);
        m.x_iter     = $urandom;
        m.y_iter     = $urandom;
        m.z_iter     = $urandom;
        m.r          = $urandom;
        m.dr         = $urandom;
        m.march_depth = ($urandom_range(0, 9) == 0) ? number'(32'h7fff_0000 + $urandom_range(0, 65535))
                                                     : number'($urandom_range(0, 17 * 65536));
        m.logdist    = ($urandom_range(0, 9) == 0) ? number'($urandom) : number'(int'($urandom_range(0, 3 * 65536)) - 32768);
        m.epsilon    = number'($urandom_range(0, 4096));
        return m;
    endfunction

    initial begin
        message m;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        pix_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_outputs('0);
        rst_n     = 1'b1;
        pix_ready = 1'b1;

        // Single continue step along +x.
        m = base_msg();
        m.logdist = 32'sh0000_8000;
        send(m);
        tick();
        tick();
        chk("r035_loop_valid", loop_valid, 1'b1);
        chk("r035_pos_x", loop_out.pos_x, 32'sh0000_8000);
        chk("r035_pos_z", loop_out.pos_z, -32'sd131072);
        chk("r035_depth", loop_out.march_depth, 32'sh0000_8000);
        chk("r035_iter", loop_out.march_iter, 8'd1);
        chk("r035_dr", loop_out.dr, 32'sh0001_0000);
        chk("r035_x_iter", loop_out.x_iter, 32'sh0000_8000);

        // Surface hit.
        m = base_msg();
        m.logdist    = 32'sd33;
        m.march_iter = 8'd7;
        m.mem_addr   = 16'd100;
        send(m);
        tick();
        tick();
        chk("r036_pix_valid", pix_valid, 1'b1);
        chk("r036_addr", pix_addr, 16'd100);
        chk("r036_hit", pix_hit, 1'b1);
        chk("r036_steps", pix_steps, 8'd8);
        chk("r036_loop_valid", loop_valid, 1'b0);
        tick();

        // Depth limit miss, then the same ray with a hit distance.
        m = base_msg();
        m.march_depth = 32'sd1015808;
        m.logdist     = 32'sd39322;
        send(m);
        tick();
        tick();
        chk("r037_hit", pix_hit, 1'b0);
        chk("r037_depth", pix_depth, 32'sd1055130);
        tick();
        m.logdist = 32'sd7;
        send(m);
        tick();
        tick();
        chk("r037_prio_hit", pix_hit, 1'b1);
        tick();

        // Iteration limit miss.
        m = base_msg();
        m.march_iter  = 8'd63;
        m.logdist     = 32'sd13107;
        m.march_depth = ONE;
        send(m);
        tick();
        tick();
        chk("r038_hit", pix_hit, 1'b0);
        chk("r038_steps", pix_steps, 8'd64);
        tick();

        // Five terminations into a stalled FIFO, then drain in order.
        pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m = base_msg();
            m.mem_addr = 16'(200 + i);
            in_valid   = 1'b1;
            data_in    = m;
            tick();
        end
        in_valid = 1'b0;
        data_in  = '0;
        repeat (3) tick();
        chk("r039_pix_valid", pix_valid, 1'b1);
        chk("r039_overflow", fifo_overflow, 1'b1);
        pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("r039_drain_addr", pix_addr, 16'(200 + i));
            tick();
        end
        chk("r039_empty", pix_valid, 1'b0);
        do_reset();

        // Reset with rays in flight.
        for (int i = 0; i < 3; i++) begin
            m = base_msg();
            m.logdist  = 32'sh0000_8000;
            m.mem_addr = 16'(300 + i);
            in_valid   = 1'b1;
            data_in    = m;
            tick();
        end
        do_reset();
        repeat (5) tick();

        // Random stream with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            in_valid  = 1'($urandom_range(0, 1));
            data_in   = in_valid ? rnd_msg() : '0;
            pix_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        data_in   = '0;
        pix_ready = 1'b1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
